// File: rtl/aes_decrypt_iter_pkg.sv
// Shared definitions for the iterative AES inverse cipher.
// Contents: forward/inverse S-box tables, GF(2^8) helpers, FSM state
// encodings, round-counter width and Nr/Nk constants for AES-128/192/256.
package aes_decrypt_iter_pkg;

   localparam int unsigned NR_128 = 10;
   localparam int unsigned NK_128 = 4;
   localparam int unsigned NR_192 = 12;
   localparam int unsigned NK_192 = 6;
   localparam int unsigned NR_256 = 14;
   localparam int unsigned NK_256 = 8;

   localparam int unsigned RND_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Source byte for InvShiftRows: row r of column c comes from column (c-r) mod 4.
   function automatic int unsigned inv_shift_src(input int unsigned b);
      return 4 * (((b / 4) + 4 - (b % 4)) % 4) + (b % 4);
   endfunction

endpackage

// File: rtl/aes_decrypt_iter_inv_cipher_round.sv
// One combinational AES inverse-cipher round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when is_final).
// Ports: state_in/round_key/state_out 128-bit, byte 0 in [127:120]; is_final 1-bit.
module inv_cipher_round import aes_decrypt_iter_pkg::*; (
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         is_final,
   output logic [127:0] state_out
);

   logic [127:0] sub;
   logic [127:0] ark;
   logic [127:0] imc;

   always_comb begin
      sub = '0;
      for (int unsigned b = 0; b < 16; b++) begin
         sub[127-8*b -: 8] = INV_SBOX[state_in[127-8*inv_shift_src(b) -: 8]];
      end
      ark = sub ^ round_key;
      imc = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         imc[127-32*c -: 8] = gf_mul14(ark[127-32*c -: 8]) ^ gf_mul11(ark[119-32*c -: 8]) ^
                              gf_mul13(ark[111-32*c -: 8]) ^ gf_mul9(ark[103-32*c -: 8]);
         imc[119-32*c -: 8] = gf_mul9(ark[127-32*c -: 8])  ^ gf_mul14(ark[119-32*c -: 8]) ^
                              gf_mul11(ark[111-32*c -: 8]) ^ gf_mul13(ark[103-32*c -: 8]);
         imc[111-32*c -: 8] = gf_mul13(ark[127-32*c -: 8]) ^ gf_mul9(ark[119-32*c -: 8])  ^
                              gf_mul14(ark[111-32*c -: 8]) ^ gf_mul11(ark[103-32*c -: 8]);
         imc[103-32*c -: 8] = gf_mul11(ark[127-32*c -: 8]) ^ gf_mul13(ark[119-32*c -: 8]) ^
                              gf_mul9(ark[111-32*c -: 8])  ^ gf_mul14(ark[103-32*c -: 8]);
      end
      state_out = is_final ? ark : imc;
   end

endmodule

// File: rtl/aes_decrypt_iter_key_expansion.sv
// Combinational AES key schedule (keyExpansion).
// Ports: key [N-1:0] cipher key; fullkeys [128*(Nr+1)-1:0] all round keys,
// round key 0 in the most significant 128-bit slice.
module key_expansion import aes_decrypt_iter_pkg::*; #(
   parameter int unsigned N  = 128,
   parameter int unsigned Nr = NR_128,
   parameter int unsigned Nk = NK_128
) (
   input  logic [N-1:0]            key,
   output logic [128*(Nr+1)-1:0]   fullkeys
);

   localparam int unsigned NW = 4 * (Nr + 1);
   localparam int unsigned KW = 128 * (Nr + 1);

   function automatic logic [KW-1:0] expand(input logic [N-1:0] k);
      logic [31:0] w [NW];
      logic [31:0] t;
      logic [7:0]  rc;
      logic [KW-1:0] fk;
      rc = 8'h01;
      fk = '0;
      for (int unsigned i = 0; i < NW; i++) begin
         if (i < Nk) begin
            w[i] = k[N-1-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % Nk == 0) begin
               t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
         end
         fk[KW-1-32*i -: 32] = w[i];
      end
      return fk;
   endfunction

   assign fullkeys = expand(key);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, ct[127:0], key[N-1:0];
// out_valid/out_ready, pt[127:0] (byte 0 in [127:120]).
// Build option: define AES_DEC_TWO_ROUND_EN to retire two rounds per clock
// (requires even Nr, true for all AES variants).
module aes_decrypt_iter import aes_decrypt_iter_pkg::*; #(
   parameter int unsigned N  = 128,
   parameter int unsigned Nr = NR_128,
   parameter int unsigned Nk = NK_128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct,
   input  logic [N-1:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt
);

   localparam int unsigned KW = 128 * (Nr + 1);

   logic [1:0]       fsm, fsm_d;
   logic [127:0]     state_q, state_d;
   logic [RND_W-1:0] rnd, rnd_d;
   logic [N-1:0]     key_q, key_d;
   logic [N-1:0]     kx_in;
   logic [KW-1:0]    fullkeys;
   logic [127:0]     rk [Nr+1];
   logic [127:0]     r1_out;

   // In IDLE the schedule runs on the key port so the initial AddRoundKey
   // can use rk[Nr] in the accepting cycle; afterwards it runs on key_q.
   assign kx_in = (fsm == ST_IDLE) ? key : key_q;

   key_expansion #(.N(N), .Nr(Nr), .Nk(Nk)) u_key_expansion (
      .key      (kx_in),
      .fullkeys (fullkeys)
   );

   for (genvar r = 0; r < Nr + 1; r++) begin : g_rk
      assign rk[r] = fullkeys[KW-1-128*r -: 128];
   end

`ifdef AES_DEC_TWO_ROUND_EN
   logic [127:0] r2_out;

   // rnd is always odd in RUN; the second stage handles rk[0] as the final round.
   inv_cipher_round u_round0 (
      .state_in  (state_q),
      .round_key (rk[rnd]),
      .is_final  (1'b0),
      .state_out (r1_out)
   );
   inv_cipher_round u_round1 (
      .state_in  (r1_out),
      .round_key (rk[rnd - RND_W'(1)]),
      .is_final  (rnd == RND_W'(1)),
      .state_out (r2_out)
   );
`else
   inv_cipher_round u_round0 (
      .state_in  (state_q),
      .round_key (rk[rnd]),
      .is_final  (rnd == '0),
      .state_out (r1_out)
   );
`endif

   // Next-state, datapath and counter update.
   always_comb begin
      fsm_d   = fsm;
      state_d = state_q;
      rnd_d   = rnd;
      key_d   = key_q;
      case (fsm)
         ST_IDLE: begin
            if (in_valid) begin
               key_d   = key;
               state_d = ct ^ rk[RND_W'(Nr)];
               rnd_d   = RND_W'(Nr - 1);
               fsm_d   = ST_RUN;
            end
         end
         ST_RUN: begin
`ifdef AES_DEC_TWO_ROUND_EN
            state_d = r2_out;
            if (rnd == RND_W'(1)) fsm_d = ST_DONE;
            else                  rnd_d = rnd - RND_W'(2);
`else
            state_d = r1_out;
            if (rnd == '0) fsm_d = ST_DONE;
            else           rnd_d = rnd - RND_W'(1);
`endif
         end
         ST_DONE: begin
            if (out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // State registers; handshake flags are registered decodes of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= ST_IDLE;
         state_q   <= '0;
         rnd       <= '0;
         key_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         fsm       <= fsm_d;
         state_q   <= state_d;
         rnd       <= rnd_d;
         key_q     <= key_d;
         in_ready  <= (fsm_d == ST_IDLE);
         out_valid <= (fsm_d == ST_DONE);
      end
   end

   assign pt = state_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter (AES-128 default parameters).
// Expected plaintexts come from FIPS-197 vectors and from a forward AES model
// built here from GF(2^8) arithmetic (S-box derived, not tabulated).
module tb_aes_decrypt_iter;

`ifdef AES_DEC_TWO_ROUND_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 11;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] sb [256];

   aes_decrypt_iter u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box = affine transform of the multiplicative inverse.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Forward AES-128 cipher used to produce ciphertexts for round-trip checks.
   function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [7:0]   s [16];
      logic [7:0]   u [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 44; i++) begin
         if (i < 4) w[i] = k[127-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % 4 == 0) begin
               t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
         end
      end
      for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int b = 0; b < 16; b++) u[b] = sb[s[b]];
         for (int b = 0; b < 16; b++) s[b] = u[4*(((b/4) + (b%4)) % 4) + (b%4)];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
      end
      res = '0;
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Present one block, measure latency (accepting edge counts as edge 1),
   // optionally stall the output for 'hold' cycles while poking in_valid.
   task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] c,
                            input logic [127:0] exp_pt, input int hold, input bit poke);
      int edges;
      @(negedge clk);
      check_eq({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      key      = k;
      ct       = c;
      @(negedge clk);
      in_valid = 1'b0;
      key      = rand128();
      ct       = rand128();
      edges    = 1;
      while (!out_valid && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      check_eq({tag, "_latency"}, 128'(edges), 128'(LAT));
      check_eq({tag, "_pt"}, pt, exp_pt);
      for (int i = 0; i < hold; i++) begin
         if (poke) in_valid = 1'b1;
         @(negedge clk);
         check_eq({tag, "_hold_pt"}, pt, exp_pt);
         check_eq({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
         check_eq({tag, "_hold_out_valid"}, 128'(out_valid), 128'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
      check_eq({tag, "_out_valid_after"}, 128'(out_valid), 128'(0));
      check_eq({tag, "_pt_after"}, pt, exp_pt);
   endtask

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   initial begin
      logic [127:0] rk_key;
      logic [127:0] rk_pt;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      key       = '0;
      ct        = '0;
      build_sbox();
      #12;
      check_eq("reset_in_ready", 128'(in_ready), 128'(1));
      check_eq("reset_out_valid", 128'(out_valid), 128'(0));
      check_eq("reset_pt", pt, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_block("c1", C1_KEY, C1_CT, C1_PT, 0, 1'b0);
      run_block("appb", B_KEY, B_CT, B_PT, 0, 1'b0);
      run_block("bp", C1_KEY, C1_CT, C1_PT, 20, 1'b1);
      run_block("b2b_c1", C1_KEY, C1_CT, C1_PT, 0, 1'b0);
      run_block("b2b_appb", B_KEY, B_CT, B_PT, 0, 1'b0);

      // Asynchronous reset in the middle of the round sequence.
      @(negedge clk);
      in_valid = 1'b1;
      key      = B_KEY;
      ct       = B_CT;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
      check_eq("midrst_pt", pt, 128'(0));
      check_eq("midrst_in_ready", 128'(in_ready), 128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_block("after_rst_c1", C1_KEY, C1_CT, C1_PT, 0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         rk_key = rand128();
         rk_pt  = rand128();
         run_block("rand", rk_key, aes_enc(rk_key, rk_pt), rk_pt,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
